pad_in_conditioner: RTL and testbench

Parametrised multi-channel input conditioner for asynchronous pad inputs (fetch enable, GPIO-style inputs, spare inputs) in the chip top. It generalises the fixed 2-stage single-signal synchroniser: configurable channel count and synchroniser depth, a per-channel digital glitch filter with runtime threshold, rise/fall edge detection, and sticky pending flags with an aggregate interrupt. It sits between the pad cells and croc_domain/user_domain, and is clocked by the SoC clock.

---
 rtl/pad_cond_pkg.sv | 14 +
 rtl/pad_cond_channel.sv | 92 +++++++++
 rtl/pad_in_conditioner.sv | 70 +++++++
 tb/tb_pad_in_conditioner.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_cond_pkg.sv
// Shared types and helpers for the pad input conditioner.
package pad_cond_pkg;

  parameter int DefaultCntWidth = 8;
  localparam int MaxCh = 32;

  typedef logic [DefaultCntWidth-1:0] cnt_t;

  // A threshold of zero is treated as one so the filter can never stall.
  function automatic logic [31:0] eff_thresh(input logic [31:0] t);
    return (t == 32'd0) ? 32'd1 : t;
  endfunction

endpackage

// File: rtl/pad_cond_channel.sv
// One pad channel: synchroniser, glitch filter, edge detect and sticky pending flag.
module pad_cond_channel
  import pad_cond_pkg::*;
#(
  parameter int   SyncStages = 2,
  parameter int   CntWidth   = 8,
  parameter logic ResetValue = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                testmode_i,
  input  logic                async_i,
  input  logic                filt_en_i,
  input  logic [CntWidth-1:0] thresh_i,
  input  logic                rise_en_i,
  input  logic                fall_en_i,
  input  logic                clr_i,
  output logic                sync_o,
  output logic                filt_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic                pend_o
);

  logic [SyncStages-1:0] sync_d, sync_q;
  logic [CntWidth-1:0]   cnt_d, cnt_q;
  logic                  filt_d, filt_q;
  logic                  prev_d, prev_q;
  logic                  pend_d, pend_q;
  logic [31:0]           thr_eff;
  logic [31:0]           cnt_inc;
  logic                  bypass;
  logic                  sync_s;
  logic                  rise, fall;

  always_comb begin
    sync_d  = {sync_q[SyncStages-2:0], async_i};
    sync_s  = sync_q[SyncStages-1];
    bypass  = testmode_i | ~filt_en_i;
    thr_eff = eff_thresh(32'(thresh_i));
    cnt_inc = 32'(cnt_q) + 32'd1;
    filt_d  = filt_q;
    cnt_d   = '0;

    // A lowered threshold at or below the running count toggles on the next mismatch.
    if (bypass) begin
      filt_d = sync_s;
    end else if (sync_s != filt_q) begin
      if (cnt_inc >= thr_eff) begin
        filt_d = sync_s;
      end else begin
        cnt_d = cnt_inc[CntWidth-1:0];
      end
    end

    prev_d = filt_q;
    rise   = filt_q & ~prev_q;
    fall   = ~filt_q & prev_q;

    // Set beats clear when both happen in the same cycle.
    if ((rise & rise_en_i) | (fall & fall_en_i)) begin
      pend_d = 1'b1;
    end else if (clr_i) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SyncStages{ResetValue}};
      cnt_q  <= '0;
      filt_q <= ResetValue;
      prev_q <= ResetValue;
      pend_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      prev_q <= prev_d;
      pend_q <= pend_d;
    end
  end

  assign sync_o = sync_s;
  assign filt_o = filt_q;
  assign rise_o = rise;
  assign fall_o = fall;
  assign pend_o = pend_q;

endmodule

// File: rtl/pad_in_conditioner.sv
// Multi-channel pad input conditioner with aggregate registered interrupt.
module pad_in_conditioner
  import pad_cond_pkg::*;
#(
  parameter int   NumCh      = 4,
  parameter int   SyncStages = 2,
  parameter int   CntWidth   = 8,
  parameter logic ResetValue = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                testmode_i,
  input  logic [NumCh-1:0]    async_i,
  input  logic [NumCh-1:0]    filt_en_i,
  input  logic [CntWidth-1:0] thresh_i,
  input  logic [NumCh-1:0]    rise_en_i,
  input  logic [NumCh-1:0]    fall_en_i,
  input  logic [NumCh-1:0]    clr_i,
  output logic [NumCh-1:0]    sync_o,
  output logic [NumCh-1:0]    filt_o,
  output logic [NumCh-1:0]    rise_o,
  output logic [NumCh-1:0]    fall_o,
  output logic [NumCh-1:0]    pend_o,
  output logic                irq_o
);

  if (NumCh < 1 || NumCh > MaxCh) begin : g_bad_numch
    $error("pad_in_conditioner: NumCh out of range");
  end

  for (genvar i = 0; i < NumCh; i++) begin : g_ch
    pad_cond_channel #(
      .SyncStages (SyncStages),
      .CntWidth   (CntWidth),
      .ResetValue (ResetValue)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .testmode_i (testmode_i),
      .async_i    (async_i[i]),
      .filt_en_i  (filt_en_i[i]),
      .thresh_i   (thresh_i),
      .rise_en_i  (rise_en_i[i]),
      .fall_en_i  (fall_en_i[i]),
      .clr_i      (clr_i[i]),
      .sync_o     (sync_o[i]),
      .filt_o     (filt_o[i]),
      .rise_o     (rise_o[i]),
      .fall_o     (fall_o[i]),
      .pend_o     (pend_o[i])
    );
  end

  logic irq_d, irq_q;

  always_comb begin
    irq_d = |pend_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_pad_in_conditioner.sv
// Self-checking bench: vector table, directed corner sequences and random run against a reference model.
module tb_pad_in_conditioner;

  localparam int NumCh      = 4;
  localparam int SyncStages = 2;
  localparam int CntWidth   = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                tm;
  logic [NumCh-1:0]    async_v, fen, ren, fal_en, clr;
  logic [CntWidth-1:0] thr;
  logic [NumCh-1:0]    sync_o, filt_o, rise_o, fall_o, pend_o;
  logic                irq_o;

  always #5 clk = ~clk;

  pad_in_conditioner #(
    .NumCh      (NumCh),
    .SyncStages (SyncStages),
    .CntWidth   (CntWidth),
    .ResetValue (1'b0)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .testmode_i (tm),
    .async_i    (async_v),
    .filt_en_i  (fen),
    .thresh_i   (thr),
    .rise_en_i  (ren),
    .fall_en_i  (fal_en),
    .clr_i      (clr),
    .sync_o     (sync_o),
    .filt_o     (filt_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .pend_o     (pend_o),
    .irq_o      (irq_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: sync is a sample delay line; each filtered level follows the
  // synchronised level once it has disagreed for max(thresh,1) consecutive cycles.
  logic [NumCh-1:0] m_pipe [SyncStages];
  logic [NumCh-1:0] m_filt, m_prev, m_pend;
  logic             m_irq;
  int               m_run [NumCh];

  always @(posedge clk or negedge rst_n) begin : model
    logic [NumCh-1:0] s, nf, ev;
    int t;
    if (!rst_n) begin
      for (int i = 0; i < SyncStages; i++) m_pipe[i] <= '0;
      m_filt <= '0;
      m_prev <= '0;
      m_pend <= '0;
      m_irq  <= 1'b0;
      for (int c = 0; c < NumCh; c++) m_run[c] <= 0;
    end else begin
      s  = m_pipe[SyncStages-1];
      t  = (thr == 0) ? 1 : int'(thr);
      nf = m_filt;
      for (int c = 0; c < NumCh; c++) begin
        if (tm || !fen[c]) begin
          nf[c] = s[c];
          m_run[c] <= 0;
        end else if (s[c] == m_filt[c]) begin
          m_run[c] <= 0;
        end else if (m_run[c] + 1 >= t) begin
          nf[c] = s[c];
          m_run[c] <= 0;
        end else begin
          m_run[c] <= m_run[c] + 1;
        end
      end
      ev = (m_filt & ~m_prev & ren) | (~m_filt & m_prev & fal_en);
      m_pend <= ev | (m_pend & ~clr);
      m_irq  <= |m_pend;
      m_prev <= m_filt;
      m_filt <= nf;
      for (int i = SyncStages - 1; i > 0; i--) m_pipe[i] <= m_pipe[i-1];
      m_pipe[0] <= async_v;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_sync", sync_o, m_pipe[SyncStages-1]);
      chk("model_filt", filt_o, m_filt);
      chk("model_rise", rise_o, m_filt & ~m_prev);
      chk("model_fall", fall_o, ~m_filt & m_prev);
      chk("model_pend", pend_o, m_pend);
      chk("model_irq",  irq_o,  m_irq);
    end
  end

  typedef struct {
    logic [NumCh-1:0]    a;
    logic [NumCh-1:0]    en;
    logic                t_m;
    logic [CntWidth-1:0] th;
    int                  hold;
    logic [NumCh-1:0]    exp_sync;
    logic [NumCh-1:0]    exp_filt;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{4'hA, 4'h0, 1'b0, 8'd0,   3, 4'hA, 4'hA};
    tbl[1] = '{4'h5, 4'hF, 1'b0, 8'd3,   4, 4'h5, 4'hA};
    tbl[2] = '{4'h5, 4'hF, 1'b0, 8'd3,   1, 4'h5, 4'h5};
    tbl[3] = '{4'h0, 4'hF, 1'b1, 8'd200, 3, 4'h0, 4'h0};
    tbl[4] = '{4'hF, 4'h3, 1'b0, 8'd2,   3, 4'hF, 4'hC};
    tbl[5] = '{4'hF, 4'h3, 1'b0, 8'd2,   1, 4'hF, 4'hF};

    tm = 1'b0; async_v = 4'hF; fen = '0; ren = '0; fal_en = '0; clr = '0; thr = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    chk_on = 1'b1;

    // Reset hold and release with all inputs high
    tick(3);
    chk("rst_sync", sync_o, 4'h0);
    chk("rst_filt", filt_o, 4'h0);
    chk("rst_rise", rise_o, 4'h0);
    chk("rst_pend", pend_o, 4'h0);
    chk("rst_irq",  irq_o,  1'b0);
    rst_n = 1'b1;
    tick(1);
    chk("rel_sync1", sync_o, 4'h0);
    chk("rel_rise1", rise_o, 4'h0);
    tick(1);
    chk("rel_sync2", sync_o, 4'hF);
    chk("rel_filt2", filt_o, 4'h0);
    tick(1);
    chk("rel_filt3", filt_o, 4'hF);
    chk("rel_rise3", rise_o, 4'hF);
    tick(1);
    chk("rel_rise4", rise_o, 4'h0);

    for (int i = 0; i < 6; i++) begin
      async_v = tbl[i].a; fen = tbl[i].en; tm = tbl[i].t_m; thr = tbl[i].th;
      tick(tbl[i].hold);
      chk($sformatf("tbl%0d_sync", i), sync_o, tbl[i].exp_sync);
      chk($sformatf("tbl%0d_filt", i), filt_o, tbl[i].exp_filt);
    end

    // Glitch rejection at threshold 5
    fen = 4'hF; thr = 8'd5; async_v = 4'h0;
    tick(10);
    clr = 4'hF; tick(1); clr = '0;
    ren = 4'h1;
    async_v = 4'h1; tick(4); async_v = 4'h0; tick(12);
    chk("glitch4_filt", filt_o[0], 1'b0);
    chk("glitch4_pend", pend_o, 4'h0);
    async_v = 4'h1; tick(2);
    chk("p5_sync", sync_o[0], 1'b1);
    tick(3); async_v = 4'h0;
    tick(1);
    chk("p5_filt_early", filt_o[0], 1'b0);
    tick(1);
    chk("p5_filt", filt_o[0], 1'b1);
    chk("p5_rise", rise_o[0], 1'b1);
    chk("p5_pend0", pend_o[0], 1'b0);
    tick(1);
    chk("p5_rise_end", rise_o[0], 1'b0);
    chk("p5_pend", pend_o[0], 1'b1);
    chk("p5_irq0", irq_o, 1'b0);
    tick(1);
    chk("p5_irq", irq_o, 1'b1);
    tick(8);

    // Threshold 0 behaves as 1
    ren = '0;
    clr = 4'hF; tick(1); clr = '0; tick(1);
    chk("th0_irq_clr", irq_o, 1'b0);
    thr = 8'd0;
    async_v = 4'h1; tick(1); async_v = 4'h0;
    tick(2);
    chk("th0_filt_hi", filt_o[0], 1'b1);
    tick(1);
    chk("th0_filt_lo", filt_o[0], 1'b0);

    // Set/clear collision on channel 1
    fal_en = 4'h2;
    async_v = 4'h2; tick(4);
    chk("col_filt_hi", filt_o[1], 1'b1);
    async_v = 4'h0; tick(3);
    chk("col_fall", fall_o[1], 1'b1);
    clr = 4'h2; tick(1); clr = '0;
    chk("col_pend", pend_o[1], 1'b1);
    tick(1);
    chk("col_irq", irq_o, 1'b1);
    clr = 4'h2; tick(1); clr = '0;
    chk("clr_pend", pend_o[1], 1'b0);
    chk("clr_irq_lag", irq_o, 1'b1);
    tick(1);
    chk("clr_irq", irq_o, 1'b0);
    fal_en = '0;

    // Testmode bypass and leaving testmode mid-count
    thr = 8'd200; fen = 4'hF; tm = 1'b1; async_v = 4'hF;
    tick(2);
    chk("tm_sync", sync_o, 4'hF);
    tick(1);
    chk("tm_filt", filt_o, 4'hF);
    tm = 1'b0; async_v = 4'h0;
    tick(10);
    chk("tm_drop_hold", filt_o, 4'hF);
    tm = 1'b1; tick(1);
    chk("tm_back", filt_o, 4'h0);
    tm = 1'b0;

    // Asynchronous reset during a partial count
    thr = 8'd10; async_v = 4'hF;
    tick(5);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_sync", sync_o, 4'h0);
    chk("ar_filt", filt_o, 4'h0);
    chk("ar_pend", pend_o, 4'h0);
    chk("ar_irq",  irq_o,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    chk("ar_sync_rel", sync_o, 4'hF);
    tick(9);
    chk("ar_filt_wait", filt_o, 4'h0);
    tick(1);
    chk("ar_filt_rel", filt_o, 4'hF);

    // Randomised traffic checked cycle by cycle against the model
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NumCh; c++) begin
        if ($urandom_range(3) == 0) async_v[c] = ~async_v[c];
      end
      if ($urandom_range(31) == 0) thr = CntWidth'($urandom_range(6));
      if ($urandom_range(63) == 0) fen = NumCh'($urandom);
      if ($urandom_range(127) == 0) tm = ~tm;
      if ($urandom_range(15) == 0) begin
        ren = NumCh'($urandom);
        fal_en = NumCh'($urandom);
      end
      clr = ($urandom_range(7) == 0) ? NumCh'($urandom) : '0;
      tick(1);
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
